// File: rtl/pos_remote_link_ctrl.sv
// Remote endpoint of the position ring: TX FIFO toward the link
// with back pressure, RX hold register toward the ring node.

package MD_pkg;
  localparam int PARTICLE_ID_WIDTH    = 9;
  localparam int OFFSET_WIDTH         = 16;
  localparam int GLOBAL_CELL_ID_WIDTH = 3;
  localparam int NB_CELL_COUNT_WIDTH  = 3;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] particle_id;
    logic [OFFSET_WIDTH-1:0]      offset_z;
    logic [OFFSET_WIDTH-1:0]      offset_y;
    logic [OFFSET_WIDTH-1:0]      offset_x;
  } offset_packet_t;

  localparam int OFFSET_PKT_STRUCT_WIDTH =
    $bits(offset_packet_t);
endpackage

module pos_remote_link_ctrl
  import MD_pkg::*;
#(
  parameter  int TX_DEPTH = 16,
  parameter  int BP_SLACK = 4,
  localparam int OW = OFFSET_PKT_STRUCT_WIDTH,
  localparam int GW = 3 * GLOBAL_CELL_ID_WIDTH,
  localparam int LW = NB_CELL_COUNT_WIDTH,
  localparam int W  = OW + GW + LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [OW-1:0] i_node_offset_pkt,
  input  logic [GW-1:0] i_node_gcid,
  input  logic [LW-1:0] i_node_lifetime,
  input  logic          i_node_valid,
  output logic          o_node_back_pressure,
  output logic [W-1:0]  o_link_tx_data,
  output logic          o_link_tx_valid,
  input  logic          i_link_tx_ready,
  input  logic [W-1:0]  i_link_rx_data,
  input  logic          i_link_rx_valid,
  output logic          o_link_rx_ready,
  output logic [OW-1:0] o_remote_offset_pkt,
  output logic [GW-1:0] o_remote_gcid,
  output logic [LW-1:0] o_remote_lifetime,
  output logic          o_remote_valid,
  input  logic          i_remote_ack,
  output logic          o_tx_overflow
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);
  localparam logic [CW-1:0] BP_THR =
    CW'(TX_DEPTH - BP_SLACK);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } rx_state_e;

  logic [W-1:0]  r_tx_mem [TX_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_tx_count;
  logic          r_bp;
  logic          r_ovf;

  logic [W-1:0]  w_node_rec;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [CW-1:0] w_cnt_nxt;

  rx_state_e     r_rx_state;
  logic [W-1:0]  r_rx_hold;
  logic          w_rx_fire;

  assign w_node_rec =
    {i_node_lifetime, i_node_gcid, i_node_offset_pkt};

  assign w_full = (r_tx_count == FULL_CNT);
  assign w_pop  = (r_tx_count != '0) && i_link_tx_ready;
  // A pop frees the slot, so a write into a full FIFO still lands
  assign w_wr   = i_node_valid && (!w_full || w_pop);
  assign w_drop = i_node_valid && w_full && !w_pop;

  assign w_cnt_nxt = r_tx_count
                   + CW'(w_wr)
                   - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_tx_mem[r_wr_ptr] <= w_node_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tx_count <= '0;
      r_bp       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_ovf    <= 1'b1;
      r_tx_count <= w_cnt_nxt;
      r_bp       <= (w_cnt_nxt >= BP_THR);
    end
  end

  assign o_link_tx_valid      = (r_tx_count != '0);
  // Gate stale RAM contents so the link sees zeros when empty
  assign o_link_tx_data       =
    o_link_tx_valid ? r_tx_mem[r_rd_ptr] : '0;
  assign o_node_back_pressure = r_bp;
  assign o_tx_overflow        = r_ovf;

  assign o_link_rx_ready =
    (r_rx_state == S_IDLE) || i_remote_ack;
  assign w_rx_fire = i_link_rx_valid && o_link_rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= S_IDLE;
      r_rx_hold  <= '0;
    end else begin
      unique case (r_rx_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            r_rx_hold  <= i_link_rx_data;
            r_rx_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_rx_fire) begin
            r_rx_hold <= i_link_rx_data;
          end else if (i_remote_ack) begin
            r_rx_state <= S_IDLE;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  assign o_remote_valid = (r_rx_state == S_HOLD);
  assign {o_remote_lifetime,
          o_remote_gcid,
          o_remote_offset_pkt} = r_rx_hold;

endmodule

// File: tb/tb_pos_remote_link_ctrl.sv
// Scoreboard bench for pos_remote_link_ctrl: directed TX/RX
// vectors, negedge monitor pops expected records.

module tb_pos_remote_link_ctrl;
  import MD_pkg::*;

  localparam int OW = OFFSET_PKT_STRUCT_WIDTH;
  localparam int GW = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int LW = NB_CELL_COUNT_WIDTH;
  localparam int W  = OW + GW + LW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [OW-1:0] i_node_offset_pkt;
  logic [GW-1:0] i_node_gcid;
  logic [LW-1:0] i_node_lifetime;
  logic          i_node_valid;
  logic          o_node_back_pressure;
  logic [W-1:0]  o_link_tx_data;
  logic          o_link_tx_valid;
  logic          i_link_tx_ready;
  logic [W-1:0]  i_link_rx_data;
  logic          i_link_rx_valid;
  logic          o_link_rx_ready;
  logic [OW-1:0] o_remote_offset_pkt;
  logic [GW-1:0] o_remote_gcid;
  logic [LW-1:0] o_remote_lifetime;
  logic          o_remote_valid;
  logic          o_tx_overflow;
  logic          ack_reg;
  logic          ack_follow;
  wire           w_ack = ack_follow ? o_remote_valid : ack_reg;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] tx_q [$];
  logic [W-1:0] rx_q [$];

  always #5 clk = ~clk;

  pos_remote_link_ctrl #(
    .TX_DEPTH(16),
    .BP_SLACK(4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_node_offset_pkt   (i_node_offset_pkt),
    .i_node_gcid         (i_node_gcid),
    .i_node_lifetime     (i_node_lifetime),
    .i_node_valid        (i_node_valid),
    .o_node_back_pressure(o_node_back_pressure),
    .o_link_tx_data      (o_link_tx_data),
    .o_link_tx_valid     (o_link_tx_valid),
    .i_link_tx_ready     (i_link_tx_ready),
    .i_link_rx_data      (i_link_rx_data),
    .i_link_rx_valid     (i_link_rx_valid),
    .o_link_rx_ready     (o_link_rx_ready),
    .o_remote_offset_pkt (o_remote_offset_pkt),
    .o_remote_gcid       (o_remote_gcid),
    .o_remote_lifetime   (o_remote_lifetime),
    .o_remote_valid      (o_remote_valid),
    .i_remote_ack        (w_ack),
    .o_tx_overflow       (o_tx_overflow)
  );

  function automatic void chk(string nm,
                              logic [127:0] act,
                              logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] mk(int pid, int x,
                                      int y, int z,
                                      logic [8:0] g,
                                      int life);
    offset_packet_t p;
    p.particle_id = PARTICLE_ID_WIDTH'(pid);
    p.offset_x    = OFFSET_WIDTH'(x);
    p.offset_y    = OFFSET_WIDTH'(y);
    p.offset_z    = OFFSET_WIDTH'(z);
    return {NB_CELL_COUNT_WIDTH'(life), g, p};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_link_tx_valid && i_link_tx_ready) begin
        if (tx_q.size() == 0)
          chk("tx_unexpected", o_link_tx_data, '0);
        else
          chk("tx_data", o_link_tx_data, tx_q.pop_front());
      end
      if (o_remote_valid && w_ack) begin
        if (rx_q.size() == 0)
          chk("rx_unexpected", o_remote_valid, 1'b0);
        else
          chk("rx_data",
              {o_remote_lifetime, o_remote_gcid,
               o_remote_offset_pkt},
              rx_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic node_wr(logic [W-1:0] rec);
    i_node_valid = 1'b1;
    {i_node_lifetime, i_node_gcid, i_node_offset_pkt} = rec;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    tx_q.delete();
    rx_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [95:0]  rnd;
  logic [W-1:0] rec;
  int           nvalid;

  initial begin
    rst_n = 1'b1;
    ack_follow = 1'b0;
    ack_reg = 1'b0;
    i_node_valid = 1'b0;
    i_link_tx_ready = 1'b0;
    i_link_rx_valid = 1'b0;
    i_link_rx_data = '0;
    {i_node_lifetime, i_node_gcid, i_node_offset_pkt} = '0;
    #1;
    rst_n = 1'b0;
    rnd = {$urandom(), $urandom(), $urandom()};
    {i_node_lifetime, i_node_gcid, i_node_offset_pkt} =
      rnd[W-1:0];
    rnd = {$urandom(), $urandom(), $urandom()};
    i_link_rx_data  = rnd[W-1:0];
    i_node_valid    = 1'b1;
    i_link_tx_ready = 1'b1;
    i_link_rx_valid = 1'b1;
    ack_reg         = $urandom_range(0, 1);
    #21;
    chk("rst_tx_valid", o_link_tx_valid, 1'b0);
    chk("rst_tx_data", o_link_tx_data, '0);
    chk("rst_bp", o_node_back_pressure, 1'b0);
    chk("rst_ovf", o_tx_overflow, 1'b0);
    chk("rst_rem_valid", o_remote_valid, 1'b0);
    chk("rst_rx_ready", o_link_rx_ready, 1'b1);
    chk("rst_rem_data",
        {o_remote_lifetime, o_remote_gcid,
         o_remote_offset_pkt}, '0);
    i_node_valid = 1'b0;
    i_link_tx_ready = 1'b0;
    i_link_rx_valid = 1'b0;
    ack_reg = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // five entries buffered, then asynchronous reset
    for (int k = 0; k < 5; k++) begin
      node_wr(mk(100 + k, k, k, k, 9'd0, 1));
      step();
    end
    i_node_valid = 1'b0;
    chk("pre_rst_count", dut.r_tx_count, 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_count", dut.r_tx_count, 0);
    chk("async_tx_valid", o_link_tx_valid, 1'b0);
    apply_reset();

    // single packet with one-cycle latency
    i_link_tx_ready = 1'b1;
    rec = mk(7, 1, 2, 3, 9'b000000000, 4);
    node_wr(rec);
    tx_q.push_back(rec);
    step();
    i_node_valid = 1'b0;
    chk("single_latency", o_link_tx_valid, 1'b1);
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_link_tx_valid) nvalid++;
      step();
    end
    chk("single_cycles", nvalid, 1);

    // fill, back pressure, overflow, drain
    i_link_tx_ready = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      rec = mk(k, 10 * k, 20 * k, 30 * k, 9'(k), k % 8);
      node_wr(rec);
      if (k <= 16) tx_q.push_back(rec);
      step();
      chk($sformatf("bp_fill%0d", k),
          o_node_back_pressure, (k >= 12));
    end
    i_node_valid = 1'b0;
    chk("fill_ovf", o_tx_overflow, 1'b1);
    chk("fill_count", dut.r_tx_count, 16);
    i_link_tx_ready = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      step();
      chk($sformatf("bp_drain%0d", j),
          o_node_back_pressure, ((16 - j) >= 12));
    end
    i_link_tx_ready = 1'b0;
    chk("drain_empty", o_link_tx_valid, 1'b0);
    chk("drain_q", tx_q.size(), 0);
    chk("ovf_sticky", o_tx_overflow, 1'b1);
    apply_reset();

    // full with simultaneous write and pop
    for (int k = 0; k < 16; k++) begin
      rec = mk(200 + k, k, 2 * k, 3 * k, 9'(k), k % 8);
      node_wr(rec);
      tx_q.push_back(rec);
      step();
    end
    i_link_tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rec = mk(300 + k, 5, 6, 7, 9'h1ff, 7);
      node_wr(rec);
      tx_q.push_back(rec);
      step();
      chk("simul_count", dut.r_tx_count, 16);
      chk("simul_ovf", o_tx_overflow, 1'b0);
    end
    i_node_valid = 1'b0;
    for (int k = 0; k < 16; k++) step();
    i_link_tx_ready = 1'b0;
    chk("simul_q", tx_q.size(), 0);
    chk("simul_empty", o_link_tx_valid, 1'b0);

    // RX with delayed ack
    rec = mk(5, 0, 0, 0, 9'b010010010, 3);
    i_link_rx_valid = 1'b1;
    i_link_rx_data = rec;
    rx_q.push_back(rec);
    #1;
    chk("rx_idle_ready", o_link_rx_ready, 1'b1);
    step();
    i_link_rx_valid = 1'b0;
    rnd = {$urandom(), $urandom(), $urandom()};
    i_link_rx_data = rnd[W-1:0];
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rx_hold_valid", o_remote_valid, 1'b1);
      chk("rx_hold_ready", o_link_rx_ready, 1'b0);
      chk("rx_hold_data",
          {o_remote_lifetime, o_remote_gcid,
           o_remote_offset_pkt}, rec);
      step();
    end
    ack_reg = 1'b1;
    #1;
    chk("rx_ack_ready", o_link_rx_ready, 1'b1);
    step();
    ack_reg = 1'b0;
    chk("rx_after_ack", o_remote_valid, 1'b0);
    ack_reg = 1'b1;
    step();
    ack_reg = 1'b0;
    chk("rx_idle_ack", o_remote_valid, 1'b0);

    // RX back-to-back with ack following valid
    ack_follow = 1'b1;
    for (int b = 0; b < 4; b++) begin
      rec = mk(40 + b, b, b + 1, b + 2, 9'(b * 73), b + 1);
      i_link_rx_valid = 1'b1;
      i_link_rx_data = rec;
      rx_q.push_back(rec);
      #1;
      chk($sformatf("b2b_ready%0d", b), o_link_rx_ready, 1'b1);
      step();
      chk($sformatf("b2b_valid%0d", b), o_remote_valid, 1'b1);
    end
    i_link_rx_valid = 1'b0;
    step();
    ack_follow = 1'b0;
    chk("b2b_done", o_remote_valid, 1'b0);
    chk("b2b_q", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
